// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between N producers, the arbiter and a single consumer.
// master: the producer/consumer side; slave: the arbiter.
interface rr_mux_arb_if #(
   parameter int unsigned N     = 3,
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned SW = $clog2(N);

   logic [1:0]         mode;
   logic [SW-1:0]      sel;
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SW-1:0]      out_src;
   logic               out_ready;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/rr_mux_arb.sv
// N-way registered mux/arbiter: explicit select, round-robin or fixed priority
// selection into a one-entry output register with valid/ready on both sides.
module rr_mux_arb #(
   parameter int unsigned N     = 3,
   parameter int unsigned WIDTH = 16
) (
   input logic         clk,
   input logic         reset,
   rr_mux_arb_if.slave bus
);
   localparam int unsigned SW = $clog2(N);

   logic [N-1:0]     grant;
   logic [SW-1:0]    grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             any_grant;
   logic             found;
   logic             free;

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [SW-1:0]    out_src_q;
   logic [SW-1:0]    rr_ptr_q;

   // Pick at most one requester according to the current mode.
   always_comb begin
      grant = '0;
      found = 1'b0;
      case (bus.mode)
         2'd0: begin
            // sel >= N matches no channel, so no grant.
            for (int i = 0; i < int'(N); i++) begin
               if (bus.sel == SW'(i)) grant[i] = bus.in_valid[i];
            end
         end
         2'd1: begin
            // First pass covers rr_ptr..N-1, second pass wraps to 0..rr_ptr-1.
            for (int i = 0; i < int'(N); i++) begin
               if (!found && i >= int'(rr_ptr_q) && bus.in_valid[i]) begin
                  grant[i] = 1'b1;
                  found    = 1'b1;
               end
            end
            for (int i = 0; i < int'(N); i++) begin
               if (!found && bus.in_valid[i]) begin
                  grant[i] = 1'b1;
                  found    = 1'b1;
               end
            end
         end
         default: begin
            for (int i = 0; i < int'(N); i++) begin
               if (!found && bus.in_valid[i]) begin
                  grant[i] = 1'b1;
                  found    = 1'b1;
               end
            end
         end
      endcase
   end

   // Encode the one-hot grant and steer the granted channel's data.
   always_comb begin
      grant_idx  = '0;
      grant_data = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (grant[i]) begin
            grant_idx  = SW'(i);
            grant_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign any_grant     = |grant;
   assign free          = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = (reset && free) ? grant : '0;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;

   // Output register and round-robin pointer; load, drain or hold on stall.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= '0;
      end else if (free) begin
         if (any_grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_src_q   <= grant_idx;
            if (bus.mode == 2'd1) begin
               rr_ptr_q <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule
